// File: rtl/add_arb_pkg.sv
// Shared types for the add_arbiter slice: FSM state encoding and a constant clog2 helper.
package add_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/add_arbiter_if.sv
// Requester/result bus of add_arbiter. Result handshake: a result transfers on the clock
// edge where res_valid_o1 & res_ready_i1 are both high; valid and payload hold until then.
interface add_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  import add_arb_pkg::*;
  localparam int IDW = clog2(N);

  logic [N-1:0]   req_i1;
  logic [N*W-1:0] opa_i1;
  logic [N*W-1:0] opb_i1;
  logic [N-1:0]   gnt_o1;
  logic [W-1:0]   res_o1;
  logic           carry_o1;
  logic [IDW-1:0] res_id_o1;
  logic           res_valid_o1;
  logic           res_ready_i1;
  arb_state_t     dbg_state;

  modport master (
    output req_i1, opa_i1, opb_i1, res_ready_i1,
    input  gnt_o1, res_o1, carry_o1, res_id_o1, res_valid_o1, dbg_state
  );

  modport slave (
    input  req_i1, opa_i1, opb_i1, res_ready_i1,
    output gnt_o1, res_o1, carry_o1, res_id_o1, res_valid_o1, dbg_state
  );
endinterface

// File: rtl/add_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to the
// lowest set request when nothing at or above ptr is asking.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] idx
);

  logic           found_hi;
  logic [IDW-1:0] idx_hi;
  logic [IDW-1:0] idx_lo;

  // Scanning downwards leaves the lowest qualifying index as the final assignment.
  always_comb begin
    found_hi = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx_lo = IDW'(i);
        if (IDW'(i) >= ptr) begin
          found_hi = 1'b1;
          idx_hi   = IDW'(i);
        end
      end
    end
  end

  assign any = |req;
  assign idx = found_hi ? idx_hi : idx_lo;

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter sequencing N requesters onto one registered W-bit adder.
// Optional ADD_ARB_SAT_EN: saturate res_o1 to all-ones on carry (carry_o1 still reports it).
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic         arb_c1,
  input  logic         arb_rstn_i1,
  add_arbiter_if.slave bus
);

  localparam int IDW = clog2(N);

  arb_state_t     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] k;
  logic [W-1:0]   opa_q;
  logic [W-1:0]   opb_q;
  logic [N-1:0]   gnt;
  logic [W-1:0]   res;
  logic           carry;
  logic [IDW-1:0] res_id;
  logic           res_valid;

  logic           any;
  logic [IDW-1:0] idx;
  logic [W-1:0]   opa_arr [N];
  logic [W-1:0]   opb_arr [N];
  logic [W:0]     sum_full;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req (bus.req_i1),
    .ptr (ptr),
    .any (any),
    .idx (idx)
  );

  always_comb begin
    for (int i = 0; i < N; i++) begin
      opa_arr[i] = bus.opa_i1[i*W +: W];
      opb_arr[i] = bus.opb_i1[i*W +: W];
    end
  end

  assign sum_full = {1'b0, opa_q} + {1'b0, opb_q};

  always_ff @(posedge arb_c1 or negedge arb_rstn_i1) begin
    if (!arb_rstn_i1) begin
      state     <= IDLE;
      ptr       <= '0;
      k         <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      gnt       <= '0;
      res       <= '0;
      carry     <= 1'b0;
      res_id    <= '0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            k     <= idx;
            opa_q <= opa_arr[idx];
            opb_q <= opb_arr[idx];
            gnt   <= N'(1) << idx;
            state <= EXEC;
          end
        end
        EXEC: begin
          gnt       <= '0;
          carry     <= sum_full[W];
`ifdef ADD_ARB_SAT_EN
          res       <= sum_full[W] ? '1 : sum_full[W-1:0];
`else
          res       <= sum_full[W-1:0];
`endif
          res_id    <= k;
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          // Result payload stays in place after the transfer; only valid drops.
          if (bus.res_ready_i1) begin
            res_valid <= 1'b0;
            ptr       <= (k == IDW'(N - 1)) ? '0 : k + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt_o1       = gnt;
  assign bus.res_o1       = res;
  assign bus.carry_o1     = carry;
  assign bus.res_id_o1    = res_id;
  assign bus.res_valid_o1 = res_valid;
  assign bus.dbg_state    = state;

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter (N=4, W=8): reset, single op, overflow, backpressure,
// pointer wrap, reset during EXEC and a full round-robin sweep.
module tb_add_arbiter;
  import add_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rstn;

  add_arbiter_if #(.N(N), .W(W)) bus ();

  add_arbiter #(.N(N), .W(W)) dut (
    .arb_c1      (clk),
    .arb_rstn_i1 (rstn),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int since_gnt  = 0;
  logic [W-1:0] sat_exp;
  logic [W-1:0] sum_tab [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    since_gnt++;
  endtask

  task automatic set_ops(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.opa_i1[k*W +: W] = a;
    bus.opb_i1[k*W +: W] = b;
  endtask

  task automatic wait_gnt(input int budget);
    int n;
    n = 0;
    while (bus.gnt_o1 == '0 && n < budget) begin
      tick();
      n++;
    end
    chk("gnt_seen", 32'(bus.gnt_o1 != '0), 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef ADD_ARB_SAT_EN
    sat_exp = 8'hFF;
`else
    sat_exp = 8'h01;
`endif
    sum_tab[0] = 8'h11;
    sum_tab[1] = 8'h22;
    sum_tab[2] = 8'h33;
    sum_tab[3] = 8'h44;

    rstn             = 1'b0;
    bus.req_i1       = '0;
    bus.opa_i1       = '0;
    bus.opb_i1       = '0;
    bus.res_ready_i1 = 1'b0;

    // reset state
    #3;
    chk("rst_gnt",   32'(bus.gnt_o1), 32'h0);
    chk("rst_valid", 32'(bus.res_valid_o1), 32'h0);
    chk("rst_res",   32'(bus.res_o1), 32'h0);
    chk("rst_carry", 32'(bus.carry_o1), 32'h0);
    chk("rst_id",    32'(bus.res_id_o1), 32'h0);
    chk("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    tick();
    tick();
    rstn = 1'b1;
    tick();
    chk("idle_noreq_state", 32'(bus.dbg_state), 32'(IDLE));
    chk("idle_noreq_gnt",   32'(bus.gnt_o1), 32'h0);

    // single request
    set_ops(0, 8'h12, 8'h34);
    bus.req_i1 = 4'b0001;
    tick();
    chk("single_gnt",   32'(bus.gnt_o1), 32'h1);
    chk("single_state", 32'(bus.dbg_state), 32'(EXEC));
    chk("single_valid_early", 32'(bus.res_valid_o1), 32'h0);
    bus.req_i1 = 4'b0000;
    tick();
    chk("single_gnt_off", 32'(bus.gnt_o1), 32'h0);
    chk("single_valid",   32'(bus.res_valid_o1), 32'h1);
    chk("single_res",     32'(bus.res_o1), 32'h46);
    chk("single_carry",   32'(bus.carry_o1), 32'h0);
    chk("single_id",      32'(bus.res_id_o1), 32'h0);
    bus.res_ready_i1 = 1'b1;
    tick();
    chk("single_valid_drop", 32'(bus.res_valid_o1), 32'h0);
    bus.res_ready_i1 = 1'b0;

    // overflow on requester 1, then backpressure with others pending
    set_ops(1, 8'hFF, 8'h02);
    set_ops(2, 8'h80, 8'h7F);
    set_ops(3, 8'h05, 8'h06);
    bus.req_i1 = 4'b0010;
    tick();
    chk("ovf_gnt", 32'(bus.gnt_o1), 32'h2);
    bus.req_i1 = 4'b0101;
    tick();
    chk("ovf_valid", 32'(bus.res_valid_o1), 32'h1);
    chk("ovf_carry", 32'(bus.carry_o1), 32'h1);
    chk("ovf_res",   32'(bus.res_o1), 32'(sat_exp));
    chk("ovf_id",    32'(bus.res_id_o1), 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(bus.res_valid_o1), 32'h1);
      chk("bp_res",   32'(bus.res_o1), 32'(sat_exp));
      chk("bp_id",    32'(bus.res_id_o1), 32'h1);
      chk("bp_gnt",   32'(bus.gnt_o1), 32'h0);
    end
    bus.res_ready_i1 = 1'b1;
    tick();
    chk("bp_release_valid", 32'(bus.res_valid_o1), 32'h0);
    chk("bp_release_state", 32'(bus.dbg_state), 32'(IDLE));
    tick();
    chk("rr_after_1_gnt", 32'(bus.gnt_o1), 32'h4);
    bus.req_i1 = 4'b0001;
    tick();
    chk("rr_after_1_id",    32'(bus.res_id_o1), 32'h2);
    chk("rr_after_1_res",   32'(bus.res_o1), 32'hFF);
    chk("rr_after_1_carry", 32'(bus.carry_o1), 32'h0);
    tick();

    // pointer wrap: ptr is 3 now
    bus.req_i1 = 4'b1001;
    tick();
    chk("wrap_gnt3", 32'(bus.gnt_o1), 32'h8);
    bus.req_i1 = 4'b0001;
    tick();
    chk("wrap_id3",  32'(bus.res_id_o1), 32'h3);
    chk("wrap_res3", 32'(bus.res_o1), 32'h0B);
    tick();
    tick();
    chk("wrap_gnt0", 32'(bus.gnt_o1), 32'h1);
    bus.req_i1 = 4'b0000;
    tick();
    chk("wrap_id0",  32'(bus.res_id_o1), 32'h0);
    chk("wrap_res0", 32'(bus.res_o1), 32'h46);
    tick();

    // reset during EXEC discards the operation
    set_ops(2, 8'h01, 8'h01);
    bus.req_i1 = 4'b0100;
    tick();
    chk("midrst_gnt_before", 32'(bus.gnt_o1), 32'h4);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_gnt",   32'(bus.gnt_o1), 32'h0);
    chk("midrst_state", 32'(bus.dbg_state), 32'(IDLE));
    chk("midrst_valid", 32'(bus.res_valid_o1), 32'h0);
    chk("midrst_res",   32'(bus.res_o1), 32'h0);
    chk("midrst_id",    32'(bus.res_id_o1), 32'h0);
    bus.req_i1 = 4'b0000;
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("postrst_valid", 32'(bus.res_valid_o1), 32'h0);
      chk("postrst_gnt",   32'(bus.gnt_o1), 32'h0);
    end

    // all requesting, ready held: strict rotation starting from 0
    set_ops(0, 8'h10, 8'h01);
    set_ops(1, 8'h20, 8'h02);
    set_ops(2, 8'h30, 8'h03);
    set_ops(3, 8'h40, 8'h04);
    bus.req_i1 = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      wait_gnt(8);
      chk("all_gnt", 32'(bus.gnt_o1), 32'(1) << (g % 4));
      if (g > 0) chk("all_spacing", 32'(since_gnt), 32'd3);
      since_gnt = 0;
      tick();
      chk("all_valid", 32'(bus.res_valid_o1), 32'h1);
      chk("all_id",    32'(bus.res_id_o1), 32'(g % 4));
      chk("all_res",   32'(bus.res_o1), 32'(sum_tab[g % 4]));
    end
    bus.req_i1 = 4'b0000;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
